// File: rtl/rf_writeback_queue.sv
// In-order writeback queue merging ALU and load results into one register-file write per cycle.
// Latency: accept -> rf_regwrite two edges later when empty; readies come from registered occupancy only.
module rf_writeback_queue #(
  parameter int         DEPTH       = 4,
  parameter logic [5:0] LOAD_OPCODE = 6'h23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [5:0]  alu_opcode,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  output logic [5:0]  rf_opcode,
  output logic        rf_regwrite,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  input  logic [4:0]  qry_reg1,
  input  logic [4:0]  qry_reg2,
  output logic        busy1,
  output logic        busy2,
  output logic [31:0] wb_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MEM_LIM = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ALU_LIM = CW'(DEPTH - 2);

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    alu_slot;
  logic [CW-1:0]    count;
  logic             mem_push;
  logic             alu_push;
  logic             pop;
  logic [DEPTH-1:0] occupied;

  // ALU keeps one slot in reserve so a simultaneous load always fits.
  assign mem_ready = (count <= MEM_LIM);
  assign alu_ready = (count <= ALU_LIM);

  // Writes to r0 complete the handshake but are dropped.
  assign mem_push = mem_valid && mem_ready && (mem_dest != 5'd0);
  assign alu_push = alu_valid && alu_ready && (alu_dest != 5'd0);
  assign pop      = (count != '0);
  assign alu_slot = wr_ptr + PW'(mem_push);

  always_ff @(posedge clk) begin
    if (mem_push) fifo_q[wr_ptr]   <= {LOAD_OPCODE, mem_dest, mem_data};
    if (alu_push) fifo_q[alu_slot] <= {alu_opcode, alu_dest, alu_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rf_regwrite   <= 1'b0;
      rf_opcode     <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      wb_count      <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
      count  <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        rf_regwrite   <= 1'b1;
        rf_opcode     <= fifo_q[rd_ptr].opcode;
        rf_write_reg  <= fifo_q[rd_ptr].dest;
        rf_write_data <= fifo_q[rd_ptr].data;
        wb_count      <= wb_count + 32'd1;
      end else begin
        rf_regwrite   <= 1'b0;
        rf_opcode     <= '0;
        rf_write_reg  <= '0;
        rf_write_data <= '0;
      end
    end
  end

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (fifo_q[i].dest == qry_reg1)) busy1 = 1'b1;
      if (occupied[i] && (fifo_q[i].dest == qry_reg2)) busy2 = 1'b1;
    end
    if (rf_regwrite && (rf_write_reg == qry_reg1)) busy1 = 1'b1;
    if (rf_regwrite && (rf_write_reg == qry_reg2)) busy2 = 1'b1;
    if (qry_reg1 == 5'd0) busy1 = 1'b0;
    if (qry_reg2 == 5'd0) busy2 = 1'b0;
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed table, corner sequences and random traffic vs a queue model.
module tb_rf_writeback_queue;
  localparam int         DEPTH   = 4;
  localparam logic [5:0] LOAD_OP = 6'h23;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [5:0]  alu_opcode;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic [5:0]  rf_opcode;
  logic        rf_regwrite;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [4:0]  qry_reg1, qry_reg2;
  logic        busy1, busy2;
  logic [31:0] wb_count;

  int checks   = 0;
  int failures = 0;

  rf_writeback_queue #(.DEPTH(DEPTH), .LOAD_OPCODE(LOAD_OP)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
    .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .rf_opcode(rf_opcode), .rf_regwrite(rf_regwrite), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data),
    .qry_reg1(qry_reg1), .qry_reg2(qry_reg2), .busy1(busy1), .busy2(busy2),
    .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending writes as a plain queue plus the output stage.
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_wr  = 1'b0;
  logic [5:0]  m_op  = '0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_dat = '0;
  logic [31:0] m_cnt = '0;
  int          issued = 0;
  logic [31:0] regs [32];

  typedef struct {
    logic        r;
    logic        av;
    logic [5:0]  aop;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mdat;
    logic [4:0]  q1;
    logic        e_ar, e_mr, e_b1;
    logic        e_wr;
    logic [5:0]  e_op;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [5:0] aop, input logic [4:0] ad,
                       input logic [31:0] adat, input logic mv, input logic [4:0] md,
                       input logic [31:0] mdat, input logic [4:0] q1, input logic [4:0] q2);
    rst_n = r; alu_valid = av; alu_opcode = aop; alu_dest = ad; alu_data = adat;
    mem_valid = mv; mem_dest = md; mem_data = mdat; qry_reg1 = q1; qry_reg2 = q2;
  endtask

  function automatic logic m_busy(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].dest == q) return 1'b1;
    return m_wr && (m_reg == q);
  endfunction

  task automatic pre_check();
    #1;
    check("alu_ready", alu_ready, mq.size() <= DEPTH - 2);
    check("mem_ready", mem_ready, mq.size() <= DEPTH - 1);
    check("busy1", busy1, m_busy(qry_reg1));
    check("busy2", busy2, m_busy(qry_reg2));
  endtask

  task automatic edge_step();
    logic mr, ar;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_wr = 1'b0; m_op = '0; m_reg = '0; m_dat = '0; m_cnt = '0;
    end else begin
      mr = (mq.size() <= DEPTH - 1);
      ar = (mq.size() <= DEPTH - 2);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wr = 1'b1; m_op = e.op; m_reg = e.dest; m_dat = e.data; m_cnt = m_cnt + 32'd1;
      end else begin
        m_wr = 1'b0; m_op = '0; m_reg = '0; m_dat = '0;
      end
      if (mem_valid && mr && mem_dest != 5'd0) mq.push_back({LOAD_OP, mem_dest, mem_data});
      if (alu_valid && ar && alu_dest != 5'd0) mq.push_back({alu_opcode, alu_dest, alu_data});
    end
    #1;
    check("rf_regwrite", rf_regwrite, m_wr);
    check("rf_opcode", rf_opcode, m_op);
    check("rf_write_reg", rf_write_reg, m_reg);
    check("rf_write_data", rf_write_data, m_dat);
    check("wb_count", wb_count, m_cnt);
    if (rf_regwrite) begin
      issued++;
      regs[rf_write_reg] = rf_write_data;
    end
  endtask

  initial begin
    logic [4:0]  mem_d [7];
    logic [4:0]  alu_d [7];
    int          mi, ai, cyc, start_issued;
    logic        mf, af, saw_alu_low;

    foreach (regs[i]) regs[i] = '0;
    //                r    av   aop    ad    adat          mv   md    mdat   q1    ar   mr   b1   wr   op     reg   dat           cnt
    vt[0]  = '{1'b0, 1'b1, 6'd0,  5'd5, 32'h1,        1'b1, 5'd6, 32'h2, 5'd5, 1'b1,1'b1,1'b0, 1'b0,6'd0,  5'd0, 32'd0,        32'd0};
    vt[1]  = '{1'b1, 1'b1, 6'd0,  5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 1'b1,1'b1,1'b0, 1'b0,6'd0,  5'd0, 32'd0,        32'd0};
    vt[2]  = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd5, 1'b1,1'b1,1'b1, 1'b1,6'd0,  5'd5, 32'hDEADBEEF, 32'd1};
    vt[3]  = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd5, 1'b1,1'b1,1'b1, 1'b0,6'd0,  5'd0, 32'd0,        32'd1};
    vt[4]  = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd5, 1'b1,1'b1,1'b0, 1'b0,6'd0,  5'd0, 32'd0,        32'd1};
    vt[5]  = '{1'b1, 1'b1, 6'h08, 5'd7, 32'd2,        1'b1, 5'd7, 32'd1, 5'd7, 1'b1,1'b1,1'b0, 1'b0,6'd0,  5'd0, 32'd0,        32'd1};
    vt[6]  = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd7, 1'b1,1'b1,1'b1, 1'b1,6'h23, 5'd7, 32'd1,        32'd2};
    vt[7]  = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd7, 1'b1,1'b1,1'b1, 1'b1,6'h08, 5'd7, 32'd2,        32'd3};
    vt[8]  = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd7, 1'b1,1'b1,1'b1, 1'b0,6'd0,  5'd0, 32'd0,        32'd3};
    vt[9]  = '{1'b1, 1'b1, 6'd0,  5'd0, 32'd5,        1'b0, 5'd0, 32'd0, 5'd0, 1'b1,1'b1,1'b0, 1'b0,6'd0,  5'd0, 32'd0,        32'd3};
    vt[10] = '{1'b1, 1'b0, 6'd0,  5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 5'd0, 1'b1,1'b1,1'b0, 1'b0,6'd0,  5'd0, 32'd0,        32'd3};

    // Reset held three cycles with both sources offering.
    drive(1'b0, 1'b1, 6'd0, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) pre_check();
      edge_step();
    end
    check("rst_regwrite", rf_regwrite, 1'b0);
    check("rst_wb_count", wb_count, 32'd0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_mem_ready", mem_ready, 1'b1);

    // Directed table: single write, mem/ALU ordering to one register, r0 discard.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].r, vt[i].av, vt[i].aop, vt[i].ad, vt[i].adat,
            vt[i].mv, vt[i].md, vt[i].mdat, vt[i].q1, 5'd0);
      pre_check();
      check($sformatf("vec%0d_alu_ready", i), alu_ready, vt[i].e_ar);
      check($sformatf("vec%0d_mem_ready", i), mem_ready, vt[i].e_mr);
      check($sformatf("vec%0d_busy1", i), busy1, vt[i].e_b1);
      edge_step();
      check($sformatf("vec%0d_regwrite", i), rf_regwrite, vt[i].e_wr);
      check($sformatf("vec%0d_opcode", i), rf_opcode, vt[i].e_op);
      check($sformatf("vec%0d_reg", i), rf_write_reg, vt[i].e_reg);
      check($sformatf("vec%0d_data", i), rf_write_data, vt[i].e_dat);
      check($sformatf("vec%0d_wb_count", i), wb_count, vt[i].e_cnt);
    end
    check("r7_final", regs[7], 32'd2);

    // Fill: six back-to-back pairs, sources hold until accepted.
    for (int k = 0; k < 7; k++) begin
      mem_d[k] = 5'(k + 1);
      alu_d[k] = 5'(k + 9);
    end
    mi = 0; ai = 0; cyc = 0; saw_alu_low = 1'b0; start_issued = issued;
    while (cyc < 40 && !(mi >= 6 && ai >= 6 && mq.size() == 0)) begin
      drive(1'b1, ai < 6, 6'h08, alu_d[ai], 32'(200 + ai), mi < 6, mem_d[mi], 32'(100 + mi),
            alu_d[ai], mem_d[mi]);
      pre_check();
      mf = mem_valid && (mq.size() <= DEPTH - 1);
      af = alu_valid && (mq.size() <= DEPTH - 2);
      if (!alu_ready) saw_alu_low = 1'b1;
      edge_step();
      if (mf) mi++;
      if (af) ai++;
      cyc++;
    end
    check("fill_done", cyc < 40, 1'b1);
    check("fill_issued", issued - start_issued, 12);
    check("fill_alu_backpressure", saw_alu_low, 1'b1);

    // Reset while three entries are queued.
    drive(1'b1, 1'b1, 6'd0, 5'd2, 32'd12, 1'b1, 5'd1, 32'd11, 5'd2, 5'd3);
    pre_check(); edge_step();
    drive(1'b1, 1'b1, 6'd0, 5'd4, 32'd14, 1'b1, 5'd3, 32'd13, 5'd2, 5'd3);
    pre_check(); edge_step();
    drive(1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
    pre_check(); edge_step();
    check("rstmid_regwrite", rf_regwrite, 1'b0);
    check("rstmid_wb_count", wb_count, 32'd0);
    drive(1'b1, 1'b0, 6'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd4);
    for (int i = 0; i < 3; i++) begin
      pre_check();
      check("rstmid_busy1", busy1, 1'b0);
      edge_step();
      check("rstmid_no_issue", rf_regwrite, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 60) != 0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(4, 63)),
            5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      pre_check();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
